// File: rtl/vld_rdy_gather_buf.sv
// Ping-pong gather buffer: packs DATA_WIDTH words into NUM_WORDS-wide beats, closed when full or by slave_last.
// Optional idle auto-close of partial beats is enabled with `define VLD_RDY_GATHER_TIMEOUT_EN.
module vld_rdy_gather_buf #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_WORDS    = 4,
   parameter int CNT_WIDTH    = $clog2(NUM_WORDS + 1),
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            slave_valid,
   output logic                            slave_ready,
   input  logic                            slave_last,
   input  logic [DATA_WIDTH-1:0]           data_in,
   output logic                            master_valid,
   input  logic                            master_ready,
   output logic [NUM_WORDS*DATA_WIDTH-1:0] data_out,
   output logic [CNT_WIDTH-1:0]            master_cnt,
   output logic                            master_last
);

   localparam int IDX_WIDTH = $clog2(NUM_WORDS);

   if (NUM_WORDS < 2 || IDLE_TIMEOUT < 1) begin : g_bad_params
      $error("vld_rdy_gather_buf: NUM_WORDS must be >= 2 and IDLE_TIMEOUT >= 1");
   end

   logic [DATA_WIDTH-1:0] mem [2][NUM_WORDS];
   logic [CNT_WIDTH-1:0]  cnt [2];
   logic [1:0]            closed;
   logic [1:0]            last;
   logic                  wr_bank;
   logic                  rd_bank;

   logic                  wr_en;
   logic                  rd_en;
   logic                  wr_close;
   logic                  tmo_close;
   logic [CNT_WIDTH-1:0]  wr_cnt;
   logic [IDX_WIDTH-1:0]  wr_idx;

   assign wr_cnt       = cnt[wr_bank];
   assign wr_idx       = wr_cnt[IDX_WIDTH-1:0];
   assign slave_ready  = ~closed[wr_bank];
   assign master_valid = closed[rd_bank];
   assign wr_en        = slave_valid & slave_ready;
   assign rd_en        = master_valid & master_ready;
   assign wr_close     = wr_en & ((wr_cnt == CNT_WIDTH'(NUM_WORDS - 1)) | slave_last);

`ifdef VLD_RDY_GATHER_TIMEOUT_EN
   localparam int TMR_WIDTH = $clog2(IDLE_TIMEOUT + 1);
   logic [TMR_WIDTH-1:0] idle_tmr;

   // Close fires on the edge where the timer would reach IDLE_TIMEOUT.
   assign tmo_close = ~wr_en & (wr_cnt != '0) & ~closed[wr_bank] &
                      (idle_tmr == TMR_WIDTH'(IDLE_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_tmr <= '0;
      end else if (wr_en || (wr_cnt == '0) || tmo_close) begin
         idle_tmr <= '0;
      end else if (!closed[wr_bank]) begin
         idle_tmr <= idle_tmr + 1'b1;
      end
   end
`else
   assign tmo_close = 1'b0;
`endif

   // Word storage carries no reset; stale contents are masked on the output.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank][wr_idx] <= data_in;
      end
   end

   // Fill and drain always target different banks, so both may update in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            cnt[b] <= '0;
         end
         closed  <= '0;
         last    <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (rd_en && rd_bank == 1'(b)) begin
               cnt[b]    <= '0;
               closed[b] <= 1'b0;
               last[b]   <= 1'b0;
            end else if (wr_en && wr_bank == 1'(b)) begin
               cnt[b] <= cnt[b] + 1'b1;
               if (wr_close) begin
                  closed[b] <= 1'b1;
                  last[b]   <= slave_last;
               end
            end else if (tmo_close && wr_bank == 1'(b)) begin
               closed[b] <= 1'b1;
               last[b]   <= 1'b0;
            end
         end
         if (wr_close || tmo_close) begin
            wr_bank <= ~wr_bank;
         end
         if (rd_en) begin
            rd_bank <= ~rd_bank;
         end
      end
   end

   always_comb begin
      master_cnt  = '0;
      master_last = 1'b0;
      data_out    = '0;
      if (master_valid) begin
         master_cnt  = cnt[rd_bank];
         master_last = last[rd_bank];
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (CNT_WIDTH'(i) < cnt[rd_bank]) begin
               data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_bank][i];
            end
         end
      end
   end

endmodule

// File: tb/tb_vld_rdy_gather_buf.sv
// Scoreboard bench for vld_rdy_gather_buf: a bank model predicts handshakes and closed beats every cycle.
// Timeout behaviour is modelled when VLD_RDY_GATHER_TIMEOUT_EN is defined.
module tb_vld_rdy_gather_buf;

   localparam int DW   = 32;
   localparam int NW   = 4;
   localparam int CW   = 3;
   localparam int TOT  = NW * DW;
   localparam int IDLE = 16;

   typedef struct {
      logic [TOT-1:0] data;
      int             cnt;
      logic           last;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           slave_valid;
   logic           slave_ready;
   logic           slave_last;
   logic [DW-1:0]  data_in;
   logic           master_valid;
   logic           master_ready;
   logic [TOT-1:0] data_out;
   logic [CW-1:0]  master_cnt;
   logic           master_last;

   int vectors     = 0;
   int miscompares = 0;

   beat_t          sb_q[$];
   logic [TOT-1:0] fill_data;
   int             fill_cnt;
   int             tmr;

   vld_rdy_gather_buf #(
      .DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_WIDTH(CW), .IDLE_TIMEOUT(IDLE)
   ) dut (
      .clk(clk), .rst(rst),
      .slave_valid(slave_valid), .slave_ready(slave_ready), .slave_last(slave_last),
      .data_in(data_in),
      .master_valid(master_valid), .master_ready(master_ready),
      .data_out(data_out), .master_cnt(master_cnt), .master_last(master_last)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [TOT-1:0] obs, input logic [TOT-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model state reflects the DUT between edges; updates predict the next posedge.
   always @(negedge clk) begin
      logic exp_sready, exp_mvalid, acc, pop, tmo;
      beat_t nb;
      if (rst) begin
         sb_q.delete();
         fill_data = '0;
         fill_cnt  = 0;
         tmr       = 0;
      end else begin
         exp_sready = (sb_q.size() < 2);
         exp_mvalid = (sb_q.size() > 0);
         check_output("slave_ready", TOT'(slave_ready), TOT'(exp_sready));
         check_output("master_valid", TOT'(master_valid), TOT'(exp_mvalid));
         if (exp_mvalid) begin
            check_output("data_out", data_out, sb_q[0].data);
            check_output("master_cnt", TOT'(master_cnt), TOT'(sb_q[0].cnt));
            check_output("master_last", TOT'(master_last), TOT'(sb_q[0].last));
         end else begin
            check_output("idle_data_out", data_out, '0);
            check_output("idle_cnt", TOT'(master_cnt), '0);
            check_output("idle_last", TOT'(master_last), '0);
         end
         acc = slave_valid && exp_sready;
         pop = exp_mvalid && master_ready;
         tmo = 1'b0;
`ifdef VLD_RDY_GATHER_TIMEOUT_EN
         tmo = !acc && (fill_cnt != 0) && exp_sready && (tmr == IDLE - 1);
         if (acc || fill_cnt == 0 || tmo) tmr = 0;
         else if (exp_sready) tmr++;
`endif
         if (pop) void'(sb_q.pop_front());
         if (acc) begin
            fill_data[fill_cnt*DW +: DW] = data_in;
            fill_cnt++;
            if (fill_cnt == NW || slave_last) begin
               nb.data = fill_data; nb.cnt = fill_cnt; nb.last = slave_last;
               sb_q.push_back(nb);
               fill_data = '0;
               fill_cnt  = 0;
            end
         end else if (tmo) begin
            nb.data = fill_data; nb.cnt = fill_cnt; nb.last = 1'b0;
            sb_q.push_back(nb);
            fill_data = '0;
            fill_cnt  = 0;
         end
      end
   end

   // Called at posedge+1; holds the word until the DUT accepts it.
   task automatic apply_stimulus(input logic [DW-1:0] d, input logic l);
      int waited = 0;
      logic acc = 1'b0;
      slave_valid = 1'b1;
      slave_last  = l;
      data_in     = d;
      while (!acc && waited < 60) begin
         @(negedge clk);
         acc = slave_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      slave_valid = 1'b0;
      slave_last  = 1'b0;
      if (!acc) check_output("accept_timeout", '0, TOT'(1));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      int guard = 0;
      while ((sb_q.size() != 0 || fill_cnt != 0) && guard < 200) begin
         idle(1);
         guard++;
      end
      if (guard >= 200) check_output("drain_timeout", '0, TOT'(1));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      slave_valid  = 1'b0;
      slave_last   = 1'b0;
      data_in      = '0;
      master_ready = 1'b0;
      #2;
      check_output("rst_slave_ready", TOT'(slave_ready), TOT'(1));
      check_output("rst_master_valid", TOT'(master_valid), '0);
      check_output("rst_master_cnt", TOT'(master_cnt), '0);
      check_output("rst_master_last", TOT'(master_last), '0);
      check_output("rst_data_out", data_out, '0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(1);

      // Full beat back-to-back with consumer ready.
      master_ready = 1'b1;
      for (int i = 0; i < NW; i++) apply_stimulus(32'hA000_0000 + DW'(i), 1'b0);
      idle(3);

      // Twelve words against a stalled consumer, released later.
      master_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 12; i++) apply_stimulus($urandom, 1'b0);
         end
         begin
            idle(16);
            master_ready = 1'b1;
         end
      join
      wait_drain();

      // Partial beat closed by slave_last.
      apply_stimulus(32'hB000_0000, 1'b0);
      apply_stimulus(32'hB000_0001, 1'b1);
      idle(3);

      // Full beat then single-word last beat with consumer stalled.
      master_ready = 1'b0;
      for (int i = 0; i < NW; i++) apply_stimulus($urandom, 1'b0);
      apply_stimulus(32'hC000_0000, 1'b1);
      idle(3);
      master_ready = 1'b1;
      wait_drain();

      // Reach one closed bank plus three words in the other, then reset mid-flight.
      master_ready = 1'b0;
      for (int i = 0; i < NW; i++) apply_stimulus($urandom, 1'b0);
      master_ready = 1'b1;
      wait_drain();
      master_ready = 1'b0;
      for (int i = 0; i < NW; i++) apply_stimulus($urandom, 1'b0);
      for (int i = 0; i < 3; i++) apply_stimulus($urandom, 1'b0);
      idle(1);
      #1 rst = 1'b1;
      #1;
      check_output("async_rst_master_valid", TOT'(master_valid), '0);
      check_output("async_rst_slave_ready", TOT'(slave_ready), TOT'(1));
      check_output("async_rst_data_out", data_out, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      master_ready = 1'b1;
      for (int i = 0; i < NW; i++) apply_stimulus(32'hE000_0000 + DW'(i), 1'b0);
      wait_drain();

      // Single word then idle: auto-close only with the timeout feature.
      apply_stimulus(32'hD000_0000, 1'b0);
`ifdef VLD_RDY_GATHER_TIMEOUT_EN
      idle(IDLE + 4);
`else
      idle(100);
      for (int i = 1; i < NW; i++) apply_stimulus(32'hD000_0000 + DW'(i), 1'b0);
`endif
      wait_drain();
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
